// File: rtl/dsp48a1_seq_pkg.sv
// Shared constants for the DSP48A1 MAC sequencer: FSM state encodings,
// slice OPMODE values and the supported slice pipeline depth range.
package dsp48a1_seq_pkg;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t ST_IDLE  = 3'd0;
    localparam seq_state_t ST_CLEAR = 3'd1;
    localparam seq_state_t ST_FEED  = 3'd2;
    localparam seq_state_t ST_DRAIN = 3'd3;
    localparam seq_state_t ST_DONE  = 3'd4;

    // X=M, Z=P, add
    localparam logic [7:0] OPM_IDLE = 8'h00;
    localparam logic [7:0] OPM_MACC = 8'h09;

    localparam int LAT_MIN = 2;
    localparam int LAT_MAX = 4;

endpackage

// File: rtl/dsp48a1_valid_pipe.sv
// Tag shift register that follows valid operands through the slice pipeline
// and produces the M and P stage clock enables plus an empty indication.
module dsp48a1_valid_pipe
    import dsp48a1_seq_pkg::*;
#(
    parameter int LAT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_tag,
    output logic o_ce_m,
    output logic o_ce_p,
    output logic o_empty
);

    if (LAT < LAT_MIN || LAT > LAT_MAX) begin : g_bad_lat
        $error("dsp48a1_valid_pipe: LAT out of supported range");
    end

    // r_tag[0] marks valid data in the A/B regs; r_tag[LAT-2] feeds the P reg
    logic [LAT-2:0] r_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag <= '0;
        end else if (i_clear) begin
            r_tag <= '0;
        end else begin
            r_tag[0] <= i_tag;
            for (int i = 1; i <= LAT - 2; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign o_ce_m  = r_tag[0] & ~i_clear;
    assign o_ce_p  = r_tag[LAT-2] & ~i_clear;
    assign o_empty = ~|r_tag;

endmodule

// File: rtl/dsp48a1_mac_sequencer.sv
// Sequences one DSP48A1 slice through an N-term multiply-accumulate job.
// Optional abort input enabled by defining DSP_SEQ_ABORT_EN.
//
// state | meaning
// IDLE  | waiting for start; zero-length jobs answered here
// CLEAR | one cycle synchronous reset of the P register
// FEED  | accepting operand pairs until len handshakes are done
// DRAIN | waiting for the last product to land in P
// DONE  | result registered, result_valid high for one cycle
module dsp48a1_mac_sequencer
    import dsp48a1_seq_pkg::*;
#(
    parameter int A_W   = 18,
    parameter int B_W   = 18,
    parameter int P_W   = 48,
    parameter int LEN_W = 10,
    parameter int LAT   = 3
) (
    input  logic             clk,
    input  logic             rst,
`ifdef DSP_SEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   a_in,
    input  logic [B_W-1:0]   b_in,
    output logic [A_W-1:0]   dsp_a,
    output logic [B_W-1:0]   dsp_b,
    output logic             ce_ab,
    output logic             ce_m,
    output logic             ce_p,
    output logic             rst_p,
    output logic [7:0]       opmode,
    input  logic [P_W-1:0]   p_in,
    output logic [P_W-1:0]   result,
    output logic             result_valid
);

    seq_state_t       r_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_count;
    logic [P_W-1:0]   r_result;
    logic             r_result_valid;

    logic w_abort;
    logic w_hs;
    logic w_clear_st;
    logic w_tag_ce_m;
    logic w_tag_ce_p;
    logic w_pipe_empty;

`ifdef DSP_SEQ_ABORT_EN
    assign w_abort = abort & (r_state != ST_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    assign busy       = (r_state != ST_IDLE);
    assign in_ready   = (r_state == ST_FEED) & ~w_abort;
    assign w_hs       = in_valid & in_ready;
    assign w_clear_st = (r_state == ST_CLEAR) & ~w_abort;

    assign dsp_a  = a_in;
    assign dsp_b  = b_in;
    assign ce_ab  = w_hs;
    assign ce_m   = w_tag_ce_m;
    assign ce_p   = w_tag_ce_p | w_clear_st;
    assign rst_p  = w_clear_st;
    assign opmode = busy ? OPM_MACC : OPM_IDLE;

    assign result       = r_result;
    assign result_valid = r_result_valid;

    dsp48a1_valid_pipe #(
        .LAT (LAT)
    ) u_valid_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_abort),
        .i_tag   (w_hs),
        .o_ce_m  (w_tag_ce_m),
        .o_ce_p  (w_tag_ce_p),
        .o_empty (w_pipe_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_len          <= '0;
            r_count        <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            if (w_abort) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            if (len != '0) begin
                                r_len   <= len;
                                r_count <= '0;
                                r_state <= ST_CLEAR;
                            end else begin
                                r_result       <= '0;
                                r_result_valid <= 1'b1;
                            end
                        end
                    end
                    ST_CLEAR: r_state <= ST_FEED;
                    ST_FEED: begin
                        if (w_hs) begin
                            r_count <= r_count + LEN_W'(1);
                            if (r_count + LEN_W'(1) == r_len) begin
                                r_state <= ST_DRAIN;
                            end
                        end
                    end
                    // P settles on the same cycle the tag pipe runs empty
                    ST_DRAIN: begin
                        if (w_pipe_empty) begin
                            r_result       <= p_in;
                            r_result_valid <= 1'b1;
                            r_state        <= ST_DONE;
                        end
                    end
                    ST_DONE: r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// Directed bench for dsp48a1_mac_sequencer with a behavioural DSP48A1 slice model.
module tb_dsp48a1_mac_sequencer;

    localparam int A_W   = 18;
    localparam int B_W   = 18;
    localparam int P_W   = 48;
    localparam int LEN_W = 10;
    localparam int LAT   = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [A_W-1:0]   a_in;
    logic [B_W-1:0]   b_in;
    logic [A_W-1:0]   dsp_a;
    logic [B_W-1:0]   dsp_b;
    logic             ce_ab;
    logic             ce_m;
    logic             ce_p;
    logic             rst_p;
    logic [7:0]       opmode;
    logic [P_W-1:0]   p_in;
    logic [P_W-1:0]   result;
    logic             result_valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dsp48a1_mac_sequencer #(
        .A_W   (A_W),
        .B_W   (B_W),
        .P_W   (P_W),
        .LEN_W (LEN_W),
        .LAT   (LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .len          (len),
        .busy         (busy),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a_in         (a_in),
        .b_in         (b_in),
        .dsp_a        (dsp_a),
        .dsp_b        (dsp_b),
        .ce_ab        (ce_ab),
        .ce_m         (ce_m),
        .ce_p         (ce_p),
        .rst_p        (rst_p),
        .opmode       (opmode),
        .p_in         (p_in),
        .result       (result),
        .result_valid (result_valid)
    );

    // Slice model: A/B reg, M reg, P reg with enables and sync P reset
    logic signed [A_W-1:0] s_a;
    logic signed [B_W-1:0] s_b;
    logic signed [35:0]    s_m;
    logic [P_W-1:0]        s_p;

    always @(posedge clk) begin
        if (ce_ab) begin
            s_a <= dsp_a;
            s_b <= dsp_b;
        end
        if (ce_m) s_m <= s_a * s_b;
        if (rst_p) s_p <= '0;
        else if (ce_p && opmode == 8'h09) s_p <= s_p + {{(P_W-36){s_m[35]}}, s_m};
    end
    assign p_in = s_p;

    // Protocol monitor: CE alignment with handshakes, OPMODE, pulse counts
    logic hs_d1, hs_d2;
    int   ce_err   = 0;
    int   op_err   = 0;
    int   rstp_cnt = 0;
    int   cem_cnt  = 0;
    int   rv_cnt   = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_d1 <= 1'b0;
            hs_d2 <= 1'b0;
        end else begin
            hs_d1 <= in_valid & in_ready;
            hs_d2 <= hs_d1;
            if (ce_ab !== (in_valid & in_ready)) ce_err <= ce_err + 1;
            if (ce_m !== hs_d1) ce_err <= ce_err + 1;
            if (ce_p !== (hs_d2 | rst_p)) ce_err <= ce_err + 1;
            if (dsp_a !== a_in || dsp_b !== b_in) ce_err <= ce_err + 1;
            if (opmode !== (busy ? 8'h09 : 8'h00)) op_err <= op_err + 1;
            if (rst_p) rstp_cnt <= rstp_cnt + 1;
            if (ce_m) cem_cnt <= cem_cnt + 1;
            if (result_valid) rv_cnt <= rv_cnt + 1;
        end
    end

    logic [A_W-1:0] va [8];
    logic [B_W-1:0] vb [8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_pair(input int i, input int a, input int b);
        va[i] = a[A_W-1:0];
        vb[i] = b[B_W-1:0];
    endtask

    task automatic start_job(input int n);
        start = 1'b1;
        len   = n[LEN_W-1:0];
        @(negedge clk);
        start = 1'b0;
        len   = '0;
    endtask

    task automatic feed(input int n, input bit gaps, output time t_last);
        int g;
        t_last = 0;
        for (int i = 0; i < n; i++) begin
            a_in     = va[i];
            b_in     = vb[i];
            in_valid = 1'b1;
            g = 0;
            while (!in_ready && g < 40) begin
                @(negedge clk);
                g++;
            end
            if (g >= 40) chk("hs_timeout", {63'd0, in_ready}, 64'd1);
            t_last = $time;
            @(negedge clk);
            in_valid = 1'b0;
            if (gaps && i < n - 1) @(negedge clk);
        end
    endtask

    task automatic wait_result(input string tag, input time t_last, input logic [63:0] exp);
        int g;
        g = 0;
        while (!result_valid && g < 40) begin
            @(negedge clk);
            g++;
        end
        chk({tag, "_rv"}, {63'd0, result_valid}, 64'd1);
        chk({tag, "_res"}, {16'd0, result}, exp);
        chk({tag, "_lat"}, 64'(($time - t_last) / 10), 64'(LAT + 1));
        @(negedge clk);
        chk({tag, "_pulse"}, {63'd0, result_valid}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        time t_last;
        int  snap_rstp, snap_cem, snap_rv;

        rst = 1'b1; start = 1'b0; len = '0;
        in_valid = 1'b0; a_in = '0; b_in = '0;
        @(negedge clk);
        chk("reset_ctl", {57'd0, busy, in_ready, ce_ab, ce_m, ce_p, rst_p, result_valid}, 64'd0);
        chk("reset_opm", {56'd0, opmode}, 64'h00);
        chk("reset_res", {16'd0, result}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Job 1: continuous stream, 6 + 20 - 7 + 100
        set_pair(0, 2, 3); set_pair(1, 4, 5); set_pair(2, -1, 7); set_pair(3, 10, 10);
        snap_rstp = rstp_cnt;
        start_job(4);
        chk("j1_busy", {63'd0, busy}, 64'd1);
        feed(4, 1'b0, t_last);
        wait_result("j1", t_last, 64'd119);
        chk("j1_rstp", 64'(rstp_cnt - snap_rstp), 64'd1);

        // Job 2: bubbles between pairs, 1 + 4 + 9
        set_pair(0, 1, 1); set_pair(1, 2, 2); set_pair(2, 3, 3);
        snap_cem = cem_cnt;
        start_job(3);
        feed(3, 1'b1, t_last);
        wait_result("j2", t_last, 64'd14);
        chk("j2_cem", 64'(cem_cnt - snap_cem), 64'd3);

        // Back-to-back jobs: 25 + 1, then 12 with no carry-over
        set_pair(0, 5, 5); set_pair(1, 1, 1);
        snap_rstp = rstp_cnt;
        start_job(2);
        feed(2, 1'b0, t_last);
        wait_result("j3a", t_last, 64'd26);
        set_pair(0, 3, 4);
        start_job(1);
        feed(1, 1'b0, t_last);
        wait_result("j3b", t_last, 64'd12);
        chk("j3_rstp", 64'(rstp_cnt - snap_rstp), 64'd2);

        // Reset in FEED after 2 of 5 handshakes
        set_pair(0, 1, 2); set_pair(1, 3, 4);
        start_job(5);
        feed(2, 1'b0, t_last);
        a_in = 18'd9; b_in = 18'd9; in_valid = 1'b1;
        snap_rv = rv_cnt;
        rst = 1'b1;
        #1;
        chk("rst_ctl", {57'd0, busy, in_ready, ce_ab, ce_m, ce_p, rst_p, result_valid}, 64'd0);
        chk("rst_opm", {56'd0, opmode}, 64'h00);
        chk("rst_res", {16'd0, result}, 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_no_rv", 64'(rv_cnt - snap_rv), 64'd0);
        set_pair(0, 6, 7);
        start_job(1);
        feed(1, 1'b0, t_last);
        wait_result("j5", t_last, 64'd42);

        // Zero-length job: immediate zero result, never busy
        start = 1'b1; len = '0;
        #1;
        chk("z_busy0", {63'd0, busy}, 64'd0);
        @(negedge clk);
        start = 1'b0;
        chk("z_rv", {63'd0, result_valid}, 64'd1);
        chk("z_res", {16'd0, result}, 64'd0);
        chk("z_busy1", {63'd0, busy}, 64'd0);
        @(negedge clk);
        chk("z_pulse", {63'd0, result_valid}, 64'd0);

        // Extreme operands, start while busy ignored: 2 * 2^34
        set_pair(0, -131072, -131072); set_pair(1, -131072, -131072);
        snap_rv = rv_cnt;
        start_job(2);
        start = 1'b1; len = 10'd1;
        @(negedge clk);
        start = 1'b0; len = '0;
        feed(2, 1'b0, t_last);
        wait_result("j6", t_last, 64'h0000_0008_0000_0000);
        repeat (4) @(negedge clk);
        chk("j6_noqueue_busy", {63'd0, busy}, 64'd0);
        chk("j6_rv_count", 64'(rv_cnt - snap_rv), 64'd1);

        chk("ce_align", 64'(ce_err), 64'd0);
        chk("opmode", 64'(op_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
